dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Shares the single D-cache request/response port between NREQ requesters: the load/store buffer (port 0), the page-table walker (port 1) and optional extra ports.
- Allows exactly one outstanding D-cache transaction.
- Round-robin grant; each response is routed back to the requester that issued it.
- Sits between the MEM-stage requesters and the D-cache; the D-cache's interface is unchanged.

Parameters:
- NREQ, 2, number of requester ports; legal range 1..8.
- IDW, $clog2(NREQ) (minimum 1), width of the owner index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  pipeline flush / fence.i; abandons routing of the in-flight response.
- req_i  in  NREQ x dcache_req_t  per-requester request; valid held until granted.
- gnt_o  out  NREQ  one-hot grant pulse; the request is accepted in that cycle.
- res_o  out  NREQ x dcache_res_t  per-requester response; .valid pulses only for the owner.
- dcache_req_o  out  dcache_req_t  to D-cache.
- dcache_res_i  in  dcache_res_t  from D-cache.
- busy_o  out  1  transaction in flight (state != IDLE).
- owner_o  out  IDW  index of the current/last granted requester.

Behaviour:
- States: IDLE, WAIT, DRAIN. Reset: state=IDLE, rr_ptr=0, owner=0, gnt_o=0, busy_o=0, all res_o.valid=0, dcache_req_o.valid=0.
- IDLE arbitration:
  - Candidate set is all i with req_i[i].valid.
  - Winner is the first candidate scanning i = rr_ptr, rr_ptr+1, ... mod NREQ.
  - Same cycle: gnt_o[winner]=1; dcache_req_o = req_i[winner] with valid=1 and ready=1; owner<=winner; rr_ptr<=(winner+1) mod NREQ; state<=WAIT. Zero-cycle grant latency.
  - No candidates: dcache_req_o.valid=0; state holds.
- WAIT:
  - dcache_req_o.valid=0; all gnt_o=0.
  - On dcache_res_i.valid: res_o[owner]=dcache_res_i in the same cycle (combinational); state<=IDLE.
  - The next grant is no earlier than the following cycle. Max throughput is one transaction per (D-cache latency + 1) cycles.
- res_o[j] for j != owner: valid=0, data=0 at all times.
- flush_i:
  - In IDLE: suppresses grant for that cycle; gnt_o=0, valid=0.
  - In WAIT without a same-cycle response: state<=DRAIN.
  - In WAIT coinciding with dcache_res_i.valid: the response is NOT routed; state<=IDLE.
- DRAIN:
  - No grants; wait for dcache_res_i.valid, which is consumed silently (no res_o.valid); then state<=IDLE.
  - Further flush_i in DRAIN has no effect.
  - Guarantees the D-cache never sees a second request while one is in flight.
- Spurious dcache_res_i.valid in IDLE is ignored; no res_o pulse. Flagged by an assertion in simulation.
- A requester dropping valid before its grant is legal; it simply loses that cycle's candidacy.
- Reset mid-transaction: state returns to IDLE immediately; the D-cache is reset by the same rst_i.
- NREQ=1: rr_ptr is constant 0; behaviour is otherwise identical.

Optional Feature:
- Macro CERES_DCARB_LOCK_EN.
- With the macro: adds input lock_i[NREQ].
  - If the owner's lock_i is high when its response returns, the arbiter enters IDLE with a lock held: only the owner may be granted, and rr_ptr is not advanced. This serves AMO read-modify-write pairs and PTW multi-level walks.
  - The lock is released when the owner is granted with lock_i low, or on flush_i.
- Without the macro: lock_i does not exist; arbitration is always pure round-robin.

Decomposition:
- ceres_param additions: dcarb_state_e {IDLE, WAIT, DRAIN}; localparam DCARB_NREQ_MAX=8. dcache_req_t and dcache_res_t are reused unchanged.
- Sub-module rr_arbiter (NREQ, IDW): combinational find-first-from-pointer, with inputs req vector and ptr and outputs one-hot grant, index and any_valid. Reusable by the I-cache refill path.

Test Plan:
- Single requester: req_i[0] load to 0x8000_0010 in IDLE → gnt_o=2'b01 and dcache_req_o.valid=1 in the same cycle. Response valid with data 0xDEAD_BEEF 3 cycles later → res_o[0].valid=1, data 0xDEAD_BEEF; res_o[1].valid=0.
- Contention: both ports valid continuously, fixed 2-cycle D-cache → grants alternate 0,1,0,1; no port waits more than 1 transaction; exactly one dcache_req_o.valid per 3 cycles.
- Hold-off: port 1 raises valid while port 0's transaction is in WAIT → no gnt_o and dcache_req_o.valid=0 until the cycle after the response; then gnt_o=2'b10.
- Flush in flight: grant port 0, flush_i on the next cycle, response 4 cycles later → state DRAIN, no res_o[0].valid, busy_o=1 until the response; then port 1 is granted the following cycle.
- Flush coincident with response: res_o[0].valid=0 and state returns to IDLE in 1 cycle.
- CERES_DCARB_LOCK_EN: port 1 granted with lock_i[1]=1, port 0 also valid → port 1 is granted 3 consecutive times while locked. After a grant with lock_i[1]=0, port 0 is granted next.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the D-cache port arbiter: request/response payloads and FSM states.
package dcache_port_arbiter_pkg;

  localparam int unsigned DCACHE_AW      = 32;
  localparam int unsigned DCACHE_DW      = 32;
  localparam int unsigned DCACHE_BEW     = DCACHE_DW / 8;
  localparam int unsigned DCARB_NREQ_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [DCACHE_BEW-1:0] be;
    logic [DCACHE_AW-1:0]  addr;
    logic [DCACHE_DW-1:0]  wdata;
  } dcache_req_t;

  typedef struct packed {
    logic                 valid;
    logic [DCACHE_DW-1:0] data;
  } dcache_res_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } dcarb_state_e;

  // Owner-index width; a single requester still needs one bit.
  function automatic int unsigned dcarb_idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational find-first-from-pointer arbiter; shared by the D-cache port and I-cache refill paths.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int unsigned w_pos;

  // Scan ptr, ptr+1, ... wrapping at NREQ; first hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_pos = (32'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_pos]) begin
        o_any        = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = IDW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one D-cache port among NREQ requesters with a single outstanding transaction.
// Optional owner lock (AMO pairs, PTW walks) is enabled by defining CERES_DCARB_LOCK_EN.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = dcarb_idw(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  dcache_req_t     req_i [NREQ],
`ifdef CERES_DCARB_LOCK_EN
  input  logic [NREQ-1:0] lock_i,
`endif
  output logic [NREQ-1:0] gnt_o,
  output dcache_res_t     res_o [NREQ],
  output dcache_req_t     dcache_req_o,
  input  dcache_res_t     dcache_res_i,
  output logic            busy_o,
  output logic [IDW-1:0]  owner_o
);

  dcarb_state_e    r_state, w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr, w_rr_nxt;
  logic [IDW-1:0]  r_owner, w_owner_nxt;
  logic [NREQ-1:0] w_cand, w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_lock;

`ifdef CERES_DCARB_LOCK_EN
  logic r_lock, w_lock_nxt;
  assign w_lock = r_lock;
`else
  assign w_lock = 1'b0;
`endif

  // While locked only the previous owner is eligible.
  always_comb begin
    w_cand = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand[i] = req_i[i].valid && (!w_lock || (IDW'(i) == r_owner));
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .i_req (w_cand),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

`ifdef CERES_DCARB_LOCK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock <= 1'b0;
    end else begin
      r_lock <= w_lock_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr_ptr;
    w_owner_nxt  = r_owner;
    gnt_o        = '0;
    dcache_req_o = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      res_o[j] = '0;
    end
`ifdef CERES_DCARB_LOCK_EN
    w_lock_nxt = r_lock;
`endif

    unique case (r_state)
      IDLE: begin
        if (!flush_i && w_any) begin
          gnt_o              = w_gnt;
          dcache_req_o       = req_i[w_idx];
          dcache_req_o.valid = 1'b1;
          dcache_req_o.ready = 1'b1;
          w_owner_nxt        = w_idx;
          w_state_nxt        = WAIT;
          if (!w_lock) begin
            w_rr_nxt = IDW'((32'(w_idx) + 32'd1) % NREQ);
          end
`ifdef CERES_DCARB_LOCK_EN
          if (r_lock && !lock_i[w_idx]) begin
            w_lock_nxt = 1'b0;
          end
`endif
        end
      end
      WAIT: begin
        // A flush coinciding with the response drops it instead of routing.
        if (dcache_res_i.valid) begin
          w_state_nxt = IDLE;
          if (!flush_i) begin
            res_o[r_owner] = dcache_res_i;
`ifdef CERES_DCARB_LOCK_EN
            w_lock_nxt = lock_i[r_owner];
`endif
          end
        end else if (flush_i) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dcache_res_i.valid) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

`ifdef CERES_DCARB_LOCK_EN
    if (flush_i) begin
      w_lock_nxt = 1'b0;
    end
`endif
  end

  assign busy_o  = (r_state != IDLE);
  assign owner_o = r_owner;

  // A response with nothing in flight indicates a D-cache protocol error.
  a_no_spurious_res: assert property (
    @(posedge clk_i) disable iff (rst_i) (r_state == IDLE) |-> !dcache_res_i.valid
  );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            d_flush, s_flush;
  dcache_req_t     d_req [NREQ];
  dcache_req_t     s_req [NREQ];
  dcache_res_t     d_res, s_res;
  logic [NREQ-1:0] gnt;
  dcache_res_t     res [NREQ];
  dcache_req_t     dreq;
  logic            busy;
  logic [IDW-1:0]  owner;
`ifdef CERES_DCARB_LOCK_EN
  logic [NREQ-1:0] lock_v = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 idle, 1 response owed to owner, 2 response to be discarded.
  int m_phase, m_owner, m_lat;
  int m_order[$];
  bit auto_mode;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.NREQ(NREQ)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (d_flush),
    .req_i        (d_req),
`ifdef CERES_DCARB_LOCK_EN
    .lock_i       (lock_v),
`endif
    .gnt_o        (gnt),
    .res_o        (res),
    .dcache_req_o (dreq),
    .dcache_res_i (d_res),
    .busy_o       (busy),
    .owner_o      (owner)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_lat   = 0;
    m_order.delete();
    for (int i = 0; i < int'(NREQ); i++) m_order.push_back(i);
  endtask

  task automatic randomize_inputs();
    s_res = '0;
    if (m_phase != 0 && m_lat == 0) begin
      s_res.valid = 1'b1;
      s_res.data  = $urandom;
    end
    s_flush = ($urandom_range(0, 11) == 0);
    for (int i = 0; i < int'(NREQ); i++) begin
      if (s_req[i].valid) begin
        if ($urandom_range(0, 15) == 0) s_req[i].valid = 1'b0;
      end else if ($urandom_range(0, 2) != 0) begin
        s_req[i].valid = 1'b1;
        s_req[i].ready = 1'($urandom);
        s_req[i].we    = 1'($urandom);
        s_req[i].be    = 4'($urandom);
        s_req[i].addr  = $urandom;
        s_req[i].wdata = $urandom;
      end
    end
  endtask

  // One clock: apply staged inputs, compare against model, advance model.
  task automatic cycle();
    int              w;
    int              h;
    bit              routed;
    logic [NREQ-1:0] e_gnt;
    dcache_req_t     e_req;
    @(posedge clk);
    #1;
    if (auto_mode) randomize_inputs();
    d_req   = s_req;
    d_flush = s_flush;
    d_res   = s_res;
    #1;
    w = -1;
    if (m_phase == 0 && !d_flush) begin
      foreach (m_order[k]) if (w < 0 && d_req[m_order[k]].valid) w = m_order[k];
    end
    e_gnt = '0;
    if (w >= 0) e_gnt[w] = 1'b1;
    chk("gnt", 128'(gnt), 128'(e_gnt));
    if (w >= 0) begin
      e_req       = d_req[w];
      e_req.valid = 1'b1;
      e_req.ready = 1'b1;
      chk("dreq", 128'(dreq), 128'(e_req));
    end else begin
      chk("dreq_valid", 128'(dreq.valid), 128'(0));
    end
    routed = (m_phase == 1) && d_res.valid && !d_flush;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (j == m_owner) begin
        if (routed) chk("res_owner", 128'(res[j]), 128'(d_res));
        else        chk("res_owner_valid", 128'(res[j].valid), 128'(0));
      end else begin
        chk("res_other", 128'(res[j]), 128'(0));
      end
    end
    chk("busy", 128'(busy), 128'(m_phase != 0));
    chk("owner", 128'(owner), 128'(m_owner));

    if (w >= 0) begin
      m_phase = 1;
      m_owner = w;
      m_lat   = $urandom_range(0, 3);
      for (int k = 0; k < int'(NREQ); k++) begin
        h = m_order.pop_front();
        m_order.push_back(h);
        if (h == w) break;
      end
      s_req[w].valid = 1'b0;
    end else if (m_phase == 1) begin
      if (d_res.valid)  m_phase = 0;
      else if (d_flush) m_phase = 2;
      else if (m_lat > 0) m_lat--;
    end else if (m_phase == 2) begin
      if (d_res.valid) m_phase = 0;
      else if (m_lat > 0) m_lat--;
    end
    s_flush = 1'b0;
    s_res   = '0;
  endtask

  task automatic raise(input int p, input logic [31:0] addr);
    s_req[p].valid = 1'b1;
    s_req[p].ready = 1'b0;
    s_req[p].we    = 1'b0;
    s_req[p].be    = 4'hF;
    s_req[p].addr  = addr;
    s_req[p].wdata = 32'h0;
  endtask

  task automatic respond(input logic [31:0] data);
    s_res.valid = 1'b1;
    s_res.data  = data;
  endtask

  initial begin
    int since;
    int n_gnt;
    rst       = 1'b1;
    auto_mode = 1'b0;
    s_flush   = 1'b0;
    d_flush   = 1'b0;
    s_res     = '0;
    d_res     = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      s_req[i] = '0;
      d_req[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_gnt", 128'(gnt), 128'(0));
    chk("rst_dreq_valid", 128'(dreq.valid), 128'(0));
    chk("rst_res0_valid", 128'(res[0].valid), 128'(0));
    chk("rst_res1_valid", 128'(res[1].valid), 128'(0));
    rst = 1'b0;

    // Single requester, response three cycles after grant.
    raise(0, 32'h8000_0010);
    cycle();
    chk("t1_gnt", 128'(gnt), 128'(2'b01));
    chk("t1_dreq_valid", 128'(dreq.valid), 128'(1));
    chk("t1_addr", 128'(dreq.addr), 128'(32'h8000_0010));
    cycle();
    cycle();
    respond(32'hDEAD_BEEF);
    cycle();
    chk("t1_res0_valid", 128'(res[0].valid), 128'(1));
    chk("t1_res0_data", 128'(res[0].data), 128'(32'hDEAD_BEEF));
    chk("t1_res1_valid", 128'(res[1].valid), 128'(0));

    // Hold-off: port 1 must wait for port 0's response.
    raise(0, 32'h0000_1000);
    cycle();
    raise(1, 32'h0000_2000);
    cycle();
    chk("t2_hold_gnt", 128'(gnt), 128'(0));
    chk("t2_hold_dreq", 128'(dreq.valid), 128'(0));
    respond(32'h1111_0000);
    cycle();
    chk("t2_resp_gnt", 128'(gnt), 128'(0));
    cycle();
    chk("t2_gnt1", 128'(gnt), 128'(2'b10));
    respond(32'h2222_0000);
    cycle();

    // Flush while port 0's transaction is in flight.
    raise(0, 32'h0000_3000);
    cycle();
    chk("t3_gnt0", 128'(gnt), 128'(2'b01));
    s_flush = 1'b1;
    raise(1, 32'h0000_4000);
    cycle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("t3_drain_busy", 128'(busy), 128'(1));
      chk("t3_drain_gnt", 128'(gnt), 128'(0));
    end
    respond(32'h3333_0000);
    cycle();
    chk("t3_res0_dropped", 128'(res[0].valid), 128'(0));
    cycle();
    chk("t3_gnt1", 128'(gnt), 128'(2'b10));
    respond(32'h4444_0000);
    cycle();

    // Flush coinciding with the response.
    raise(0, 32'h0000_5000);
    cycle();
    s_flush = 1'b1;
    respond(32'h5555_0000);
    cycle();
    chk("t4_res0_dropped", 128'(res[0].valid), 128'(0));
    cycle();
    chk("t4_idle", 128'(busy), 128'(0));

    // Contention with a fixed two-cycle D-cache: 1,0,1,0 from the current pointer.
    since = -1;
    n_gnt = 0;
    for (int t = 0; t < 12; t++) begin
      if (!s_req[0].valid) raise(0, 32'h0000_6000 + 32'(t));
      if (!s_req[1].valid) raise(1, 32'h0000_7000 + 32'(t));
      if (since == 1) respond(32'(t));
      cycle();
      if (gnt != '0) begin
        chk("t5_alt", 128'(gnt), (n_gnt % 2 == 0) ? 128'(2'b10) : 128'(2'b01));
        n_gnt++;
        since = 0;
      end else if (since == 1) begin
        since = -1;
      end else if (since >= 0) begin
        since++;
      end
    end
    chk("t5_count", 128'(n_gnt), 128'(4));
    s_req[0].valid = 1'b0;
    s_req[1].valid = 1'b0;
    cycle();
    cycle();

    // Random traffic.
    auto_mode = 1'b1;
    for (int t = 0; t < 3000; t++) cycle();
    auto_mode = 1'b0;

    // Reset in the middle of a transaction.
    while (m_phase != 0) begin
      respond(32'h0);
      cycle();
    end
    for (int i = 0; i < int'(NREQ); i++) s_req[i] = '0;
    raise(1, 32'h0000_8000);
    cycle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) d_req[i] = '0;
    #1;
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_owner", 128'(owner), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_req[1] = '0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
